// File: rtl/seg_score_decoder.sv
// Multiplexed 7-segment bus snooper: filters four digit slots and
// rebuilds the displayed decimal score.
module seg_score_decoder #(
  parameter int STABLE_CNT = 4
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic [7:0]  seg_sel,
  input  logic [6:0]  seg_data,
  output logic [13:0] score,
  output logic        score_valid,
  output logic        digit_err
);

  typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

  localparam logic [3:0] SC = 4'(STABLE_CNT);

  logic [7:0]  sel_q;
  logic [6:0]  data_q;
  logic [1:0]  slot;
  logic        hit;
  logic [3:0]  dval;
  logic        dok;
  logic [3:0]  err_mask;

  logic [3:0]  cand [4];
  logic [3:0]  run  [4];
  logic [3:0]  dig  [4];
  logic [3:0]  got;

  state_t      state, state_n;
  logic        start, step, fire;
  logic [3:0]  snap [4];
  logic [13:0] acc;
  logic [1:0]  idx;

  // register the raw bus once
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      sel_q  <= '0;
      data_q <= '0;
    end else begin
      sel_q  <= seg_sel;
      data_q <= seg_data;
    end
  end

  // select line to digit slot
  always_comb begin
    hit  = 1'b1;
    slot = 2'd0;
    unique case (1'b1)
      (sel_q == 8'b11111110): slot = 2'd0;
      (sel_q == 8'b11111101): slot = 2'd1;
      (sel_q == 8'b11111011): slot = 2'd2;
      (sel_q == 8'b11110111): slot = 2'd3;
      default:                hit  = 1'b0;
    endcase
  end

  // segment pattern to digit value
  always_comb begin
    dok  = 1'b1;
    dval = 4'd0;
    case (data_q)
      7'b1000000: dval = 4'd0;
      7'b1111001: dval = 4'd1;
      7'b0100100: dval = 4'd2;
      7'b0110000: dval = 4'd3;
      7'b0011001: dval = 4'd4;
      7'b0010010: dval = 4'd5;
      7'b0000010: dval = 4'd6;
      7'b1111000: dval = 4'd7;
      7'b0000000: dval = 4'd8;
      7'b0010000: dval = 4'd9;
      default:    dok  = 1'b0;
    endcase
  end

  assign err_mask = (hit && !dok) ? (4'b0001 << slot) : 4'b0000;

  // per-slot stability filter; a fresh acceptance outranks the snapshot clear
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        cand[k] <= '0;
        run[k]  <= '0;
        dig[k]  <= '0;
      end
      got       <= '0;
      digit_err <= 1'b0;
    end else begin
      digit_err <= hit && !dok;
      if (start) got <= 4'b0000;
      if (hit) begin
        if (!dok) begin
          run[slot] <= 4'd0;
          got[slot] <= 1'b0;
        end else if (dval == cand[slot]) begin
          if (run[slot] != SC) run[slot] <= run[slot] + 4'd1;
          if (run[slot] == SC - 4'd1) begin
            dig[slot] <= cand[slot];
            got[slot] <= 1'b1;
          end
        end else begin
          cand[slot] <= dval;
          run[slot]  <= 4'd1;
        end
      end
    end
  end

  // conversion sequencing; an error this cycle vetoes the start
  always_comb begin
    state_n = state;
    start   = 1'b0;
    step    = 1'b0;
    fire    = 1'b0;
    unique case (state)
      IDLE: begin
        if (&(got & ~err_mask)) begin
          start   = 1'b1;
          state_n = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (idx == 2'd0) state_n = OUT;
      end
      OUT: begin
        fire    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // snapshot, shift-add accumulate, publish
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      for (int k = 0; k < 4; k++) snap[k] <= '0;
      acc         <= '0;
      idx         <= '0;
      score       <= '0;
      score_valid <= 1'b0;
    end else begin
      state       <= state_n;
      score_valid <= fire;
      if (start) begin
        for (int k = 0; k < 4; k++) snap[k] <= dig[k];
        acc <= '0;
        idx <= 2'd3;
      end
      if (step) begin
        acc <= (acc << 3) + (acc << 1) + {10'd0, snap[idx]};
        idx <= idx - 2'd1;
      end
      if (fire) score <= acc;
    end
  end

endmodule

// File: tb/tb_seg_score_decoder.sv
// Bench for seg_score_decoder: scenario tasks against a
// rule-level model of the filter and decimal conversion.
module tb_seg_score_decoder;

  localparam int SC = 4;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic        clk_vga = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  seg_sel = 8'hFF;
  logic [6:0]  seg_data = BLANK;
  logic [13:0] score;
  logic        score_valid;
  logic        digit_err;

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  logic [6:0] pat [10];

  int m_cand [4];
  int m_run  [4];
  int m_dig  [4];
  bit m_got  [4];
  int timer, pend, m_score;
  logic [7:0] msel;
  logic [6:0] mdata;

  int o_nv, o_ne, o_last, o_vcyc, o_ecyc;
  int m_nv, m_ne, m_last, m_vcyc, m_ecyc;

  seg_score_decoder #(.STABLE_CNT(SC)) dut (
    .clk_vga(clk_vga),
    .rst_n(rst_n),
    .seg_sel(seg_sel),
    .seg_data(seg_data),
    .score(score),
    .score_valid(score_valid),
    .digit_err(digit_err)
  );

  always #5 clk_vga = ~clk_vga;

  function automatic logic [7:0] sel_of(input int k);
    logic [7:0] one;
    one = 8'd1;
    return ~(one << k);
  endfunction

  function automatic int slot_of(input logic [7:0] s);
    for (int k = 0; k < 4; k++) if (s == sel_of(k)) return k;
    return -1;
  endfunction

  function automatic int digit_of(input logic [6:0] d);
    for (int i = 0; i < 10; i++) if (d == pat[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_cand[k] = 0; m_run[k] = 0; m_dig[k] = 0; m_got[k] = 0;
    end
    timer = 0; pend = 0; m_score = 0;
    msel = '0; mdata = '0;
  endtask

  task automatic model_edge();
    int s, d;
    bit all;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = slot_of(msel);
    d = digit_of(mdata);
    all = 1;
    for (int k = 0; k < 4; k++)
      if (!m_got[k] || (s == k && d < 0)) all = 0;
    if (timer > 0) begin
      timer--;
      if (timer == 0) begin
        m_score = pend; m_nv++; m_last = pend; m_vcyc = cyc_n;
      end
    end else if (all) begin
      pend = m_dig[3] * 1000 + m_dig[2] * 100 + m_dig[1] * 10 + m_dig[0];
      for (int k = 0; k < 4; k++) m_got[k] = 0;
      timer = 5;
    end
    if (s >= 0) begin
      if (d < 0) begin
        m_run[s] = 0; m_got[s] = 0; m_ne++; m_ecyc = cyc_n;
      end else if (d == m_cand[s]) begin
        if (m_run[s] < SC) begin
          m_run[s]++;
          if (m_run[s] == SC) begin m_dig[s] = d; m_got[s] = 1; end
        end
      end else begin
        m_cand[s] = d; m_run[s] = 1;
      end
    end
    msel = seg_sel;
    mdata = seg_data;
  endtask

  task automatic clear_obs();
    o_nv = 0; o_ne = 0; o_last = 0; o_vcyc = 0; o_ecyc = 0;
    m_nv = 0; m_ne = 0; m_last = 0; m_vcyc = 0; m_ecyc = 0;
  endtask

  task automatic cyc(input logic [7:0] s, input logic [6:0] d);
    @(negedge clk_vga);
    seg_sel = s;
    seg_data = d;
    @(posedge clk_vga);
    cyc_n++;
    model_edge();
    #1;
    if (score_valid) begin o_nv++; o_last = int'(score); o_vcyc = cyc_n; end
    if (digit_err) begin o_ne++; o_ecyc = cyc_n; end
  endtask

  task automatic hold(input int k, input int digit, input int n);
    for (int i = 0; i < n; i++) cyc(sel_of(k), pat[digit]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(8'hFF, BLANK);
  endtask

  task automatic scan(input int num, input int dwell, input bit stale);
    int p;
    for (int k = 0; k < 4; k++) begin
      p = 1;
      for (int j = 0; j < k; j++) p *= 10;
      if (stale && k > 0) cyc(sel_of(k), seg_data);
      hold(k, (num / p) % 10, dwell);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(sel_of(i), pat[i + 1]);
      checks++;
      if ({score, score_valid, digit_err} !== 16'd0) begin
        failures++;
        $display("FAIL reset_outputs cycle=%0d got score=%0d v=%0b e=%0b want 0",
                 i, score, score_valid, digit_err);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_1234();
    clear_obs();
    scan(1234, 20, 1);
    idle(8);
    checks++;
    if (o_nv !== m_nv || o_vcyc !== m_vcyc || o_last !== m_last) begin
      failures++;
      $display("FAIL s1234_events got n=%0d cyc=%0d val=%0d want n=%0d cyc=%0d val=%0d",
               o_nv, o_vcyc, o_last, m_nv, m_vcyc, m_last);
    end
    checks++;
    if (o_nv !== 1 || score !== 14'h04D2 || o_ne !== 0) begin
      failures++;
      $display("FAIL s1234_value got n=%0d score=%0d err=%0d want 1 1234 0",
               o_nv, score, o_ne);
    end
  endtask

  task automatic test_9999_0000();
    clear_obs();
    scan(9999, 20, 1);
    idle(8);
    checks++;
    if (o_nv !== 1 || o_last !== 9999 || o_vcyc !== m_vcyc) begin
      failures++;
      $display("FAIL s9999 got n=%0d val=%0d cyc=%0d want 1 9999 cyc=%0d",
               o_nv, o_last, o_vcyc, m_vcyc);
    end
    clear_obs();
    scan(0, 20, 1);
    idle(8);
    checks++;
    if (o_nv !== 1 || score !== 14'd0 || o_vcyc !== m_vcyc) begin
      failures++;
      $display("FAIL s0000 got n=%0d score=%0d cyc=%0d want 1 0 cyc=%0d",
               o_nv, score, o_vcyc, m_vcyc);
    end
  endtask

  task automatic test_filter();
    int c4;
    clear_obs();
    hold(3, 8, 6);
    hold(2, 6, 6);
    hold(1, 5, 6);
    hold(0, 7, 2);
    hold(0, 3, 4);
    c4 = cyc_n;
    idle(8);
    checks++;
    if (o_nv !== 1 || o_last !== 8653 || o_vcyc !== c4 + 7) begin
      failures++;
      $display("FAIL filter_7733 got n=%0d val=%0d cyc=%0d want 1 8653 cyc=%0d",
               o_nv, o_last, o_vcyc, c4 + 7);
    end
    checks++;
    if (o_vcyc !== m_vcyc || o_ne !== m_ne) begin
      failures++;
      $display("FAIL filter_model got cyc=%0d err=%0d want cyc=%0d err=%0d",
               o_vcyc, o_ne, m_vcyc, m_ne);
    end
  endtask

  task automatic test_blank();
    int cb;
    clear_obs();
    hold(1, 7, 6);
    cyc(sel_of(1), BLANK);
    cb = cyc_n;
    hold(3, 4, 6);
    hold(2, 2, 6);
    hold(0, 1, 6);
    idle(8);
    checks++;
    if (o_nv !== 0 || o_ne !== 1 || o_ecyc !== cb + 1) begin
      failures++;
      $display("FAIL blank_err got n=%0d errs=%0d ecyc=%0d want 0 1 ecyc=%0d",
               o_nv, o_ne, o_ecyc, cb + 1);
    end
    hold(1, 7, 6);
    idle(8);
    checks++;
    if (o_nv !== 1 || o_last !== 4271 || o_vcyc !== m_vcyc) begin
      failures++;
      $display("FAIL blank_recover got n=%0d val=%0d cyc=%0d want 1 4271 cyc=%0d",
               o_nv, o_last, o_vcyc, m_vcyc);
    end
  endtask

  task automatic test_bad_sel();
    int c;
    logic [7:0] s;
    logic [6:0] d;
    hold(3, 5, 6);
    hold(2, 5, 6);
    hold(1, 5, 6);
    hold(0, 9, 2);
    clear_obs();
    for (int i = 0; i < 12; i++) begin
      s = ($urandom_range(0, 1) == 0) ? 8'b11111100 : 8'b11111111;
      d = ($urandom_range(0, 3) == 0) ? BLANK : pat[$urandom_range(0, 9)];
      cyc(s, d);
    end
    checks++;
    if (o_nv !== 0 || o_ne !== 0) begin
      failures++;
      $display("FAIL bad_sel_pulses got n=%0d errs=%0d want 0 0", o_nv, o_ne);
    end
    hold(0, 9, 2);
    c = cyc_n;
    idle(8);
    checks++;
    if (o_nv !== 1 || o_last !== 5559 || o_vcyc !== c + 7) begin
      failures++;
      $display("FAIL bad_sel_state got n=%0d val=%0d cyc=%0d want 1 5559 cyc=%0d",
               o_nv, o_last, o_vcyc, c + 7);
    end
  endtask

  task automatic test_reset_conv();
    int guard;
    hold(0, 8, 6);
    hold(1, 6, 6);
    hold(2, 4, 6);
    guard = 0;
    while (timer != 3 && guard < 40) begin
      cyc(sel_of(3), pat[2]);
      guard++;
    end
    checks++;
    if (timer != 3) begin
      failures++;
      $display("FAIL reset_conv_wait got no conversion within %0d cycles", guard);
    end
    clear_obs();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({score, score_valid, digit_err} !== 16'd0) begin
      failures++;
      $display("FAIL reset_conv_async got score=%0d v=%0b e=%0b want 0",
               score, score_valid, digit_err);
    end
    cyc(sel_of(3), pat[2]);
    rst_n = 1'b1;
    checks++;
    if ({score, score_valid, digit_err} !== 16'd0) begin
      failures++;
      $display("FAIL reset_conv_held got score=%0d v=%0b e=%0b want 0",
               score, score_valid, digit_err);
    end
    idle(10);
    hold(3, 1, 6);
    hold(2, 3, 6);
    hold(1, 5, 6);
    idle(8);
    checks++;
    if (o_nv !== 0 || score !== 14'd0) begin
      failures++;
      $display("FAIL reset_conv_abort got n=%0d score=%0d want 0 0", o_nv, score);
    end
    hold(0, 7, 6);
    idle(8);
    checks++;
    if (o_nv !== 1 || o_last !== 1357 || o_vcyc !== m_vcyc) begin
      failures++;
      $display("FAIL reset_conv_fresh got n=%0d val=%0d cyc=%0d want 1 1357 cyc=%0d",
               o_nv, o_last, o_vcyc, m_vcyc);
    end
  endtask

  task automatic test_random();
    int num, p;
    for (int it = 0; it < 25; it++) begin
      clear_obs();
      num = $urandom_range(0, 9999);
      for (int k = 0; k < 4; k++) begin
        p = 1;
        for (int j = 0; j < k; j++) p *= 10;
        if ($urandom_range(0, 2) == 0) cyc(sel_of(k), BLANK);
        if ($urandom_range(0, 3) == 0) cyc(sel_of(k), seg_data);
        if ($urandom_range(0, 4) == 0) cyc(8'b11111100, pat[$urandom_range(0, 9)]);
        hold(k, (num / p) % 10, $urandom_range(2, 10));
      end
      idle(7);
      checks++;
      if (o_nv !== m_nv || o_vcyc !== m_vcyc || o_last !== m_last) begin
        failures++;
        $display("FAIL rand_valid it=%0d got n=%0d cyc=%0d val=%0d want n=%0d cyc=%0d val=%0d",
                 it, o_nv, o_vcyc, o_last, m_nv, m_vcyc, m_last);
      end
      checks++;
      if (o_ne !== m_ne || o_ecyc !== m_ecyc || score !== 14'(m_score)) begin
        failures++;
        $display("FAIL rand_err it=%0d got errs=%0d ecyc=%0d score=%0d want %0d %0d %0d",
                 it, o_ne, o_ecyc, score, m_ne, m_ecyc, m_score);
      end
    end
  endtask

  initial begin
    pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    model_reset();
    clear_obs();
    test_reset();
    test_1234();
    test_9999_0000();
    test_filter();
    test_blank();
    test_bad_sel();
    test_reset_conv();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish by time limit");
    $fatal(1);
  end

endmodule
